// File: rtl/rx_ram_writer_if.sv
// RX write channel between the link protocol core (master) and the receive RAM writer (slave).
// Carries the write handshake, address/data bus, flag/length strobe and end-of-message strobe.
interface rx_ram_writer_if #(
    parameter int ADDR_W = 16
);
    logic              rx_ram_req_wr;
    logic              rx_ram_rdy_wr;
    logic [ADDR_W-1:0] rx_ram_addr_in;
    logic [7:0]        rx_ram_data_in;
    logic              rx_flag_len_en;
    logic [7:0]        rx_flag;
    logic [15:0]       rx_byte_number;
    logic              rx_end_message;
    logic              rx_message_right;
    logic              rx_end_line;

    modport master (
        output rx_ram_req_wr, rx_ram_addr_in, rx_ram_data_in,
        output rx_flag_len_en, rx_flag, rx_byte_number,
        output rx_end_message, rx_message_right, rx_end_line,
        input  rx_ram_rdy_wr
    );

    modport slave (
        input  rx_ram_req_wr, rx_ram_addr_in, rx_ram_data_in,
        input  rx_flag_len_en, rx_flag, rx_byte_number,
        input  rx_end_message, rx_message_right, rx_end_line,
        output rx_ram_rdy_wr
    );
endinterface

// File: rtl/rx_ram_writer.sv
// Receive-side memory responder: answers link write requests, buffers payload, commits/discards messages.
// Optional RX_RAM_WRITER_XOR_EN adds msg_xor, the XOR of all bytes stored for the committed message.
module rx_ram_writer #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WR_WAIT    = 2,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_l,
    rx_ram_writer_if.slave        wr,
    output logic                  msg_valid,
    output logic [7:0]            msg_flag,
    output logic [15:0]           msg_len,
    output logic [15:0]           msg_wr_cnt,
    output logic                  msg_line,
    output logic [2:0]            msg_err,
    input  logic [DEPTH_LOG2-1:0] host_rd_addr,
    output logic [7:0]            host_rd_data,
    input  logic                  msg_ack,
`ifdef RX_RAM_WRITER_XOR_EN
    output logic [7:0]            msg_xor,
`endif
    output logic [7:0]            bad_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_GAP} state_e;

    localparam logic [3:0] WAIT_LOAD = (WR_WAIT > 0) ? 4'(WR_WAIT - 1) : 4'd0;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              rdy_wr_q;

    // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rdy_wr_q <= 1'b0;
        end else begin
            rdy_wr_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (wr.rx_ram_req_wr) begin
                    addr_q <= wr.rx_ram_addr_in;
                    data_q <= wr.rx_ram_data_in;
                    cnt_q  <= WAIT_LOAD;
                    if (WR_WAIT == 0) begin
                        state_q  <= S_ACK;
                        rdy_wr_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: if (cnt_q == 4'd0) begin
                    state_q  <= S_ACK;
                    rdy_wr_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                S_ACK:   state_q <= S_GAP;
                S_GAP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr.rx_ram_rdy_wr = rdy_wr_q;

    logic ack_fire, addr_oob, wr_en;
    assign ack_fire = (state_q == S_ACK);
    assign addr_oob = (addr_q >> DEPTH_LOG2) != '0;

    // Out-of-range or locked writes are still answered, just not stored.
    assign wr_en = ack_fire && !addr_oob && !msg_valid;

    logic [7:0] mem_q [2**DEPTH_LOG2];
    logic [7:0] rd_data_q;

    // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[addr_q[DEPTH_LOG2-1:0]] <= data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) rd_data_q <= '0;
        else        rd_data_q <= mem_q[host_rd_addr];
    end

    assign host_rd_data = rd_data_q;

    logic [7:0]  cur_flag_q, bad_cnt_q, bad_cnt_d;
    logic [15:0] cur_len_q, cur_cnt_q, cnt_base, cur_cnt_d;
    logic        cur_addr_err_q, cur_addr_err_d, cur_overrun_q, cur_overrun_d;
    logic        held, commit, discard;
`ifdef RX_RAM_WRITER_XOR_EN
    logic [7:0]  cur_xor_q, cur_xor_d, msg_xor_q;
`endif

    // A pending ack releases the buffer before an end-of-message in the same cycle is judged.
    assign held    = msg_valid & ~msg_ack;
    assign commit  = wr.rx_end_message & wr.rx_message_right & ~held;
    assign discard = wr.rx_end_message & ~commit;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        cnt_base  = wr.rx_flag_len_en ? 16'd0 : cur_cnt_q;
        cur_cnt_d = cnt_base;
        if (ack_fire && cnt_base != 16'hFFFF) cur_cnt_d = cnt_base + 16'd1;
        cur_addr_err_d = (wr.rx_flag_len_en ? 1'b0 : cur_addr_err_q) | (ack_fire & addr_oob);
        cur_overrun_d  = (wr.rx_flag_len_en ? 1'b0 : cur_overrun_q) | (ack_fire & msg_valid);
        bad_cnt_d = bad_cnt_q;
        if (discard && bad_cnt_q != 8'hFF) bad_cnt_d = bad_cnt_q + 8'd1;
`ifdef RX_RAM_WRITER_XOR_EN
        cur_xor_d = (wr.rx_flag_len_en ? 8'd0 : cur_xor_q) ^ (wr_en ? data_q : 8'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cur_flag_q     <= '0;
            cur_len_q      <= '0;
            cur_cnt_q      <= '0;
            cur_addr_err_q <= 1'b0;
            cur_overrun_q  <= 1'b0;
            bad_cnt_q      <= '0;
            msg_valid      <= 1'b0;
            msg_flag       <= '0;
            msg_len        <= '0;
            msg_wr_cnt     <= '0;
            msg_line       <= 1'b0;
            msg_err        <= '0;
`ifdef RX_RAM_WRITER_XOR_EN
            cur_xor_q      <= '0;
            msg_xor_q      <= '0;
`endif
        end else begin
            if (wr.rx_flag_len_en) begin
                cur_flag_q <= wr.rx_flag;
                cur_len_q  <= wr.rx_byte_number;
            end
            cur_cnt_q      <= cur_cnt_d;
            cur_addr_err_q <= cur_addr_err_d;
            cur_overrun_q  <= cur_overrun_d;
            bad_cnt_q      <= bad_cnt_d;
            msg_valid      <= held | commit;
`ifdef RX_RAM_WRITER_XOR_EN
            cur_xor_q      <= cur_xor_d;
`endif
            if (commit) begin
                msg_flag   <= cur_flag_q;
                msg_len    <= cur_len_q;
                msg_wr_cnt <= cur_cnt_d;
                msg_line   <= wr.rx_end_line;
                msg_err    <= {cur_cnt_d != cur_len_q, cur_addr_err_d, cur_overrun_d};
`ifdef RX_RAM_WRITER_XOR_EN
                msg_xor_q  <= cur_xor_d;
`endif
            end
        end
    end

    assign bad_cnt = bad_cnt_q;
`ifdef RX_RAM_WRITER_XOR_EN
    assign msg_xor = msg_xor_q;
`endif
endmodule

// File: tb/tb_rx_ram_writer.sv
// Directed self-checking bench for rx_ram_writer: one DUT with WR_WAIT = 2, one with WR_WAIT = 0.
// Inputs change one step after posedge (or at negedge); outputs are sampled at negedge.
module tb_rx_ram_writer;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [9:0]  host_rd_addr = '0, host_rd_addr0 = '0;
    logic        msg_ack = 1'b0, msg_ack0 = 1'b0;
    logic        msg_valid, msg_line, msg_valid0, msg_line0;
    logic [7:0]  msg_flag, host_rd_data, bad_cnt, msg_flag0, host_rd_data0, bad_cnt0;
    logic [15:0] msg_len, msg_wr_cnt, msg_len0, msg_wr_cnt0;
    logic [2:0]  msg_err, msg_err0;
`ifdef RX_RAM_WRITER_XOR_EN
    logic [7:0]  msg_xor, msg_xor0;
`endif
    int checks = 0;
    int errors = 0;

    rx_ram_writer_if #(.ADDR_W(16)) if0 ();
    rx_ram_writer_if #(.ADDR_W(16)) if1 ();

    rx_ram_writer #(.DEPTH_LOG2(10), .WR_WAIT(2), .ADDR_W(16)) dut (
        .clk(clk), .rst_l(rst_l), .wr(if0),
        .msg_valid(msg_valid), .msg_flag(msg_flag), .msg_len(msg_len), .msg_wr_cnt(msg_wr_cnt),
        .msg_line(msg_line), .msg_err(msg_err), .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data), .msg_ack(msg_ack),
`ifdef RX_RAM_WRITER_XOR_EN
        .msg_xor(msg_xor),
`endif
        .bad_cnt(bad_cnt)
    );

    rx_ram_writer #(.DEPTH_LOG2(10), .WR_WAIT(0), .ADDR_W(16)) dut0 (
        .clk(clk), .rst_l(rst_l), .wr(if1),
        .msg_valid(msg_valid0), .msg_flag(msg_flag0), .msg_len(msg_len0), .msg_wr_cnt(msg_wr_cnt0),
        .msg_line(msg_line0), .msg_err(msg_err0), .host_rd_addr(host_rd_addr0),
        .host_rd_data(host_rd_data0), .msg_ack(msg_ack0),
`ifdef RX_RAM_WRITER_XOR_EN
        .msg_xor(msg_xor0),
`endif
        .bad_cnt(bad_cnt0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_if();
        if0.rx_ram_req_wr = 0; if0.rx_ram_addr_in = '0; if0.rx_ram_data_in = '0;
        if0.rx_flag_len_en = 0; if0.rx_flag = '0; if0.rx_byte_number = '0;
        if0.rx_end_message = 0; if0.rx_message_right = 0; if0.rx_end_line = 0;
        if1.rx_ram_req_wr = 0; if1.rx_ram_addr_in = '0; if1.rx_ram_data_in = '0;
        if1.rx_flag_len_en = 0; if1.rx_flag = '0; if1.rx_byte_number = '0;
        if1.rx_end_message = 0; if1.rx_message_right = 0; if1.rx_end_line = 0;
    endtask

    task automatic flag_len(input logic [7:0] f, input logic [15:0] len);
        if0.rx_flag = f; if0.rx_byte_number = len; if0.rx_flag_len_en = 1;
        tick();
        if0.rx_flag_len_en = 0;
    endtask

    task automatic end_msg(input logic right, input logic line);
        if0.rx_end_message = 1; if0.rx_message_right = right; if0.rx_end_line = line;
        tick();
        if0.rx_end_message = 0; if0.rx_message_right = 0; if0.rx_end_line = 0;
    endtask

    task automatic ack_msg();
        msg_ack = 1;
        tick();
        msg_ack = 0;
    endtask

    // Single write on the WR_WAIT = 2 DUT: rdy expected on the 4th negedge after req is raised.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        int  n;
        logic got;
        n = 0; got = 0;
        if0.rx_ram_addr_in = a; if0.rx_ram_data_in = d; if0.rx_ram_req_wr = 1;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            got = if0.rx_ram_rdy_wr;
        end
        checks++;
        if (!got || n != 4) begin
            errors++;
            $display("FAIL wr_latency addr=%h got=%0d cycles rdy=%0b exp=4", a, n, got);
        end
        tick();
        if0.rx_ram_req_wr = 0;
        tick();
    endtask

    task automatic test_reset();
        int pulses, n;
        logic got;
        pulses = 0;
        rst_l = 0;
        if0.rx_ram_req_wr = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if0.rx_ram_rdy_wr) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_rdy got=%0d pulses exp=0", pulses); end
        checks++;
        if ({msg_valid, msg_flag, msg_len, msg_wr_cnt, msg_line, msg_err, host_rd_data, bad_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b flag=%h len=%h cnt=%h line=%b err=%b rd=%h bad=%h exp all 0",
                     msg_valid, msg_flag, msg_len, msg_wr_cnt, msg_line, msg_err, host_rd_data, bad_cnt);
        end
        tick();
        rst_l = 1;
        n = 0; got = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            got = if0.rx_ram_rdy_wr;
        end
        checks++;
        if (!got || n != 4) begin errors++; $display("FAIL reset_release_latency got=%0d exp=4", n); end
        tick();
        if0.rx_ram_req_wr = 0;
        tick();
    endtask

    task automatic test_basic_write();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        flag_len(8'h5A, 16'd4);
        for (int i = 0; i < 4; i++) do_write(16'(i), exp_d[i]);
        end_msg(1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_wr_cnt, msg_err, msg_line, msg_flag, msg_len} !== {1'b1, 16'd4, 3'b000, 1'b1, 8'h5A, 16'd4}) begin
            errors++;
            $display("FAIL basic_commit valid=%b cnt=%0d err=%b line=%b flag=%h len=%0d exp 1/4/000/1/5a/4",
                     msg_valid, msg_wr_cnt, msg_err, msg_line, msg_flag, msg_len);
        end
`ifdef RX_RAM_WRITER_XOR_EN
        checks++;
        if (msg_xor !== 8'h44) begin errors++; $display("FAIL basic_xor got=%h exp=44", msg_xor); end
`endif
        for (int i = 0; i < 4; i++) begin
            host_rd_addr = 10'(i);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (host_rd_data !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_read addr=%0d got=%h exp=%h", i, host_rd_data, exp_d[i]);
            end
        end
        tick();
        ack_msg();
        @(negedge clk);
        checks++;
        if (msg_valid !== 1'b0) begin errors++; $display("FAIL basic_ack valid got=%b exp=0", msg_valid); end
        tick();
    endtask

    task automatic test_wait0_hold();
        int n, pulses, last;
        if1.rx_flag = 8'h07; if1.rx_byte_number = 16'd4; if1.rx_flag_len_en = 1;
        tick();
        if1.rx_flag_len_en = 0;
        if1.rx_ram_addr_in = 16'h0005; if1.rx_ram_data_in = 8'h77; if1.rx_ram_req_wr = 1;
        n = 0; pulses = 0; last = -1;
        while (n < 30 && pulses < 4) begin
            @(negedge clk);
            n++;
            if (if1.rx_ram_rdy_wr) begin
                pulses++;
                checks++;
                if ((last < 0 && n != 2) || (last >= 0 && n - last != 3)) begin
                    errors++;
                    $display("FAIL wait0_spacing pulse=%0d at=%0d prev=%0d exp first=2 step=3", pulses, n, last);
                end
                last = n;
            end
        end
        checks++;
        if (pulses != 4) begin errors++; $display("FAIL wait0_pulses got=%0d exp=4", pulses); end
        tick();
        if1.rx_ram_req_wr = 0;
        tick();
        if1.rx_end_message = 1; if1.rx_message_right = 1;
        tick();
        if1.rx_end_message = 0; if1.rx_message_right = 0;
        @(negedge clk);
        checks++;
        if ({msg_valid0, msg_wr_cnt0, msg_err0} !== {1'b1, 16'd4, 3'b000}) begin
            errors++;
            $display("FAIL wait0_commit valid=%b cnt=%0d err=%b exp 1/4/000", msg_valid0, msg_wr_cnt0, msg_err0);
        end
        tick();
    endtask

    task automatic test_addr_err();
        flag_len(8'h01, 16'd1);
        do_write(16'h0400, 8'hEE);
        end_msg(1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_wr_cnt, msg_err, msg_line} !== {1'b1, 16'd1, 3'b010, 1'b0}) begin
            errors++;
            $display("FAIL addr_err_commit valid=%b cnt=%0d err=%b line=%b exp 1/1/010/0",
                     msg_valid, msg_wr_cnt, msg_err, msg_line);
        end
        host_rd_addr = 10'd0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (host_rd_data !== 8'h11) begin errors++; $display("FAIL addr_err_buffer got=%h exp=11", host_rd_data); end
        tick();
        ack_msg();
    endtask

    task automatic test_end_on_ack();
        int n;
        logic got;
        flag_len(8'h0E, 16'd1);
        if0.rx_ram_addr_in = 16'd20; if0.rx_ram_data_in = 8'h5C; if0.rx_ram_req_wr = 1;
        n = 0; got = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            got = if0.rx_ram_rdy_wr;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL end_on_ack_rdy got=0 exp=1"); end
        if0.rx_end_message = 1; if0.rx_message_right = 1; if0.rx_end_line = 1;
        tick();
        if0.rx_ram_req_wr = 0; if0.rx_end_message = 0; if0.rx_message_right = 0; if0.rx_end_line = 0;
        host_rd_addr = 10'd20;
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_wr_cnt, msg_err, msg_line} !== {1'b1, 16'd1, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL end_on_ack_commit valid=%b cnt=%0d err=%b line=%b exp 1/1/000/1",
                     msg_valid, msg_wr_cnt, msg_err, msg_line);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (host_rd_data !== 8'h5C) begin errors++; $display("FAIL end_on_ack_read got=%h exp=5c", host_rd_data); end
        tick();
        ack_msg();
    endtask

    task automatic test_locked();
        flag_len(8'hA1, 16'd2);
        do_write(16'd10, 8'hAA);
        do_write(16'd11, 8'hBB);
        end_msg(1'b1, 1'b0);
        flag_len(8'hB2, 16'd2);
        do_write(16'd10, 8'hCC);
        do_write(16'd11, 8'hDD);
        end_msg(1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_flag, msg_len, msg_wr_cnt, msg_err, msg_line, bad_cnt} !==
            {1'b1, 8'hA1, 16'd2, 16'd2, 3'b000, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL locked_held valid=%b flag=%h len=%0d cnt=%0d err=%b line=%b bad=%0d exp 1/a1/2/2/000/0/1",
                     msg_valid, msg_flag, msg_len, msg_wr_cnt, msg_err, msg_line, bad_cnt);
        end
        host_rd_addr = 10'd10;
        @(posedge clk);
        @(negedge clk);
        host_rd_addr = 10'd11;
        checks++;
        if (host_rd_data !== 8'hAA) begin errors++; $display("FAIL locked_read10 got=%h exp=aa", host_rd_data); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (host_rd_data !== 8'hBB) begin errors++; $display("FAIL locked_read11 got=%h exp=bb", host_rd_data); end
        tick();
        msg_ack = 1;
        @(negedge clk);
        checks++;
        if (msg_valid !== 1'b1) begin errors++; $display("FAIL ack_same_cycle valid got=%b exp=1", msg_valid); end
        tick();
        msg_ack = 0;
        @(negedge clk);
        checks++;
        if (msg_valid !== 1'b0) begin errors++; $display("FAIL ack_next_cycle valid got=%b exp=0", msg_valid); end
        tick();
        // Hold a message, then ack it in the very cycle the next one ends.
        flag_len(8'hD4, 16'd0);
        end_msg(1'b1, 1'b0);
        flag_len(8'hC3, 16'd0);
        msg_ack = 1;
        end_msg(1'b1, 1'b1);
        msg_ack = 0;
        @(negedge clk);
        checks++;
        if ({msg_valid, msg_flag, msg_wr_cnt, msg_err, msg_line, bad_cnt} !== {1'b1, 8'hC3, 16'd0, 3'b000, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ack_with_end valid=%b flag=%h cnt=%0d err=%b line=%b bad=%0d exp 1/c3/0/000/1/1",
                     msg_valid, msg_flag, msg_wr_cnt, msg_err, msg_line, bad_cnt);
        end
        tick();
        ack_msg();
    endtask

    task automatic test_bad_saturate();
        for (int i = 0; i < 256; i++) begin
            end_msg(1'b0, 1'b0);
            if (i == 99) begin
                @(negedge clk);
                checks++;
                if (bad_cnt !== 8'd101) begin errors++; $display("FAIL bad_mid got=%0d exp=101", bad_cnt); end
                tick();
            end
        end
        @(negedge clk);
        checks++;
        if ({msg_valid, bad_cnt} !== {1'b0, 8'd255}) begin
            errors++;
            $display("FAIL bad_saturate valid=%b bad=%0d exp 0/255", msg_valid, bad_cnt);
        end
        tick();
    endtask

    initial begin
        clear_if();
        test_reset();
        test_basic_write();
        test_wait0_hold();
        test_addr_err();
        test_end_on_ack();
        test_locked();
        test_bad_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_ram_writer.md
Name: rx_ram_writer

Overview:
- Receive-side memory responder for the high-speed link protocol.
- Serves the RX write channel: REQ_WR/RDY_WR handshake, address and data bus, flag/length strobe and end-of-message strobe.
- Stores payload bytes in an internal buffer, answers each write request and captures message status.
- Commits or discards each message, then exposes it to the host through a read port with an explicit release (ack).

Parameters:
- DEPTH_LOG2, 10, buffer size is 2^DEPTH_LOG2 bytes.
- WR_WAIT, 2, cycles from accepting a request to the RDY_WR pulse (0..15).
- ADDR_W, 16, width of the protocol write address.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  reset, synchronous, active-low.
- rx_ram_req_wr  in  1  write request from the protocol core.
- rx_ram_rdy_wr  out  1  one-cycle write-done pulse.
- rx_ram_addr_in  in  ADDR_W  write byte address.
- rx_ram_data_in  in  8  write byte.
- rx_flag_len_en  in  1  one-cycle strobe: rx_flag and rx_byte_number are valid.
- rx_flag  in  8  message flag/status byte.
- rx_byte_number  in  16  declared payload length.
- rx_end_message  in  1  one-cycle end-of-message strobe.
- rx_message_right  in  1  1 = message correct (qualified by rx_end_message).
- rx_end_line  in  1  0 = COM1, 1 = COM2 (qualified by rx_end_message).
- msg_valid  out  1  committed message available.
- msg_flag  out  8  flag of the committed message.
- msg_len  out  16  declared length.
- msg_wr_cnt  out  16  bytes actually written.
- msg_line  out  1  line the message arrived on.
- msg_err  out  3  {len_mismatch, addr_err, overrun}.
- host_rd_addr  in  DEPTH_LOG2  host read address.
- host_rd_data  out  8  buffer data, 1-cycle read latency.
- msg_ack  in  1  host releases the buffer.
- bad_cnt  out  8  saturating count of discarded messages.

Behaviour:
- Reset (rst_l = 0 at a clk edge): every output is 0; FSM goes to IDLE; wait counter, write counter, captured flag/length and error bits are cleared. Buffer contents are not cleared.
- Reset mid-handshake aborts the transfer; no RDY_WR pulse is issued for it.
- Write FSM:
  - IDLE: when req_wr = 1, latch address and data, load counter with WR_WAIT, go to WAIT. If WR_WAIT = 0, go straight to ACK.
  - WAIT: decrement the counter; at 0 go to ACK.
  - ACK: rdy_wr = 1 for exactly one cycle; perform the buffer write; increment msg_wr_cnt (saturate at 16'hFFFF); go to GAP.
  - GAP: req_wr is ignored for one cycle so a requester holding req across RDY is not double-accepted; go to IDLE.
- Request-to-RDY latency is WR_WAIT + 1 cycles; back-to-back throughput is one byte per WR_WAIT + 3 cycles.
- Address check: buffer index = addr[DEPTH_LOG2-1:0]. If addr >= 2^DEPTH_LOG2, the write is dropped, addr_err is set, and RDY_WR is still pulsed so the protocol core never stalls.
- Buffer locked (msg_valid = 1): incoming writes are dropped but still answered with RDY_WR; overrun is set for the incoming message.
- rx_flag_len_en: captures flag and length; clears msg_wr_cnt and the addr_err/overrun bits for the new message.
- rx_end_message with right = 1:
  - Sets msg_valid, captures the line.
  - len_mismatch = (msg_wr_cnt != msg_len).
  - A write whose ACK falls in the same cycle is counted first.
- rx_end_message with right = 0: message discarded, msg_valid stays 0, bad_cnt increments (saturates at 255).
- rx_end_message while msg_valid = 1: the new message is discarded and counted in bad_cnt; the held message is unchanged.
- msg_ack: clears msg_valid on the next cycle. msg_ack while msg_valid = 0 is ignored.
- msg_ack in the same cycle as an end-of-message strobe: the ack takes effect first, and the new message commits under the rules above.
- Host read: dual-port buffer; host_rd_data reflects host_rd_addr registered one cycle earlier. Reading a location in the same cycle it is written returns old data.

Optional Feature:
- Macro RX_RAM_WRITER_XOR_EN.
- Defined: adds output msg_xor[7:0], the running XOR of every byte accepted in ACK (dropped bytes excluded). It is cleared by rx_flag_len_en and frozen at commit.
- Not defined: the msg_xor port is absent and no XOR logic is built.

Test Plan:
- Reset with req_wr = 1 held -> all outputs 0, no rdy_wr pulse until rst_l = 1 plus WR_WAIT + 1 cycles.
- flag 8'h5A, len 4; writes 0x11, 0x22, 0x33, 0x44 at addresses 0..3; end with right = 1, line = 1 -> msg_valid = 1, msg_wr_cnt = 4, msg_err = 0, msg_line = 1; host reads addresses 0..3 -> 0x11..0x44 at 1-cycle latency.
- WR_WAIT = 0 with req_wr held high continuously -> one rdy_wr pulse every 3 cycles, no double write.
- Write to addr 16'h0400 (DEPTH_LOG2 = 10), len 1 -> rdy_wr pulsed, buffer unchanged, msg_err = 3'b010 at commit.
- Message committed and not acked; second message of 2 bytes, right = 1 -> both writes answered, first message data and msg_valid intact, bad_cnt = 1; then msg_ack -> msg_valid = 0 next cycle.
- 256 messages ended with right = 0 -> bad_cnt saturates at 255, msg_valid stays 0.
